// File: rtl/pmu_quota_pkg.sv
// Shared definitions for the PMU quota scheduler.
// Holds the sweep FSM state encoding and the default parameter values.
// Ports: none (package only).
package pmu_quota_pkg;

  localparam int DEF_REG_WIDTH  = 32;
  localparam int DEF_N_COUNTERS = 9;
  localparam int DEF_N_CORES    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2
  } state_e;

endpackage

// File: rtl/pmu_quota_satadd.sv
// Saturating unsigned adder: the sum clamps at all-ones instead of wrapping.
// Purely combinational, zero latency, no flow control.
// Ports: a_i, b_i operands; sum_o saturated sum.
module pmu_quota_satadd #(
  parameter int REG_WIDTH = 32
) (
  input  logic [REG_WIDTH-1:0] a_i,
  input  logic [REG_WIDTH-1:0] b_i,
  output logic [REG_WIDTH-1:0] sum_o
);

  logic [REG_WIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  // A carry out of the top bit means the true sum does not fit: clamp.
  assign sum_o    = full_sum[REG_WIDTH] ? '1 : full_sum[REG_WIDTH-1:0];

endmodule

// File: rtl/pmu_quota_sched.sv
// Per-core event quota scheduler: sweeps cores one at a time, sums each core's
// masked counters (N_COUNTERS cycles) then compares against its limit (1 cycle),
// raising a sticky per-core interrupt when the sum strictly exceeds the limit.
// Ports: clk_i/rstn_i (sync, active-low)/softrst_i; en_i starts sweeps;
// counter_value_i, quota_mask_i, quota_limit_i, period_i configuration inputs;
// intr_clr_i per-core clears; intr_quota_o, busy_o, sweep_done_o status.
module pmu_quota_sched
  import pmu_quota_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int N_COUNTERS = DEF_N_COUNTERS,
  parameter int N_CORES    = DEF_N_CORES
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            softrst_i,
  input  logic                            en_i,
  input  logic [N_COUNTERS*REG_WIDTH-1:0] counter_value_i,
  input  logic [N_CORES*N_COUNTERS-1:0]   quota_mask_i,
  input  logic [N_CORES*REG_WIDTH-1:0]    quota_limit_i,
  input  logic [REG_WIDTH-1:0]            period_i,
  input  logic [N_CORES-1:0]              intr_clr_i,
  output logic [N_CORES-1:0]              intr_quota_o,
  output logic                            busy_o,
  output logic                            sweep_done_o
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int KW = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N_CORES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_COUNTERS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          c_q, c_d;
  logic [KW-1:0]          k_q, k_d;
  logic [REG_WIDTH-1:0]   acc_q, acc_d;
  logic [N_COUNTERS-1:0]  mask_q, mask_d;
  logic [N_CORES-1:0]     intr_q, intr_d;
  logic                   done_q, done_d;
  logic [REG_WIDTH-1:0]   win_q, win_d;
  logic [REG_WIDTH-1:0]   period_q, period_d;

  logic [REG_WIDTH-1:0]   cnt_arr   [N_COUNTERS];
  logic [N_COUNTERS-1:0]  mask_arr  [N_CORES];
  logic [REG_WIDTH-1:0]   limit_arr [N_CORES];

  logic [N_COUNTERS-1:0]  cur_mask;
  logic [REG_WIDTH-1:0]   addend, acc_sum;
  logic [N_CORES-1:0]     set_vec;
  logic                   expire;

  for (genvar i = 0; i < N_COUNTERS; i++) begin : g_cnt
    assign cnt_arr[i] = counter_value_i[i*REG_WIDTH +: REG_WIDTH];
  end
  for (genvar n = 0; n < N_CORES; n++) begin : g_core
    assign mask_arr[n]  = quota_mask_i[n*N_COUNTERS +: N_COUNTERS];
    assign limit_arr[n] = quota_limit_i[n*REG_WIDTH +: REG_WIDTH];
  end

  assign cur_mask = mask_arr[c_q];
  assign addend   = cur_mask[k_q] ? cnt_arr[k_q] : '0;

  pmu_quota_satadd #(.REG_WIDTH(REG_WIDTH)) u_satadd (
    .a_i   (acc_q),
    .b_i   (addend),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    k_d      = k_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    set_vec  = '0;
    expire   = 1'b0;
    period_d = period_i;
    win_d    = '0;

    // Window counter: a new period value restarts the window from zero.
    if (period_i != period_q || period_i == '0) begin
      win_d = '0;
    end else if (win_q == period_i - 1'b1) begin
      win_d  = '0;
      expire = 1'b1;
    end else begin
      win_d = win_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_ACCUM;
          c_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          mask_d  = mask_arr[0];
        end
      end
      ST_ACCUM: begin
        // mask_q is the selection this core started with; a different live
        // mask means the partial sum is stale, so start this core over.
        if (cur_mask != mask_q) begin
          k_d    = '0;
          acc_d  = '0;
          mask_d = cur_mask;
        end else begin
          acc_d = acc_sum;
          if (k_q == K_LAST) begin
            state_d = ST_COMPARE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        set_vec[c_q] = (acc_q > limit_arr[c_q]);
        acc_d        = '0;
        k_d          = '0;
        if (c_q == C_LAST) begin
          c_d     = '0;
          done_d  = 1'b1;
          mask_d  = mask_arr[0];
          state_d = en_i ? ST_ACCUM : ST_IDLE;
        end else begin
          c_d     = c_q + 1'b1;
          mask_d  = mask_arr[c_q + 1'b1];
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A set beats both the clear strobe and window expiry.
    intr_d = set_vec | (intr_q & ~intr_clr_i & {N_CORES{~expire}});

    if (softrst_i) begin
      state_d = ST_IDLE;
      c_d     = '0;
      k_d     = '0;
      acc_d   = '0;
      mask_d  = '0;
      done_d  = 1'b0;
      win_d   = '0;
      intr_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      intr_q   <= '0;
      done_q   <= 1'b0;
      win_q    <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      intr_q   <= intr_d;
      done_q   <= done_d;
      win_q    <= win_d;
      period_q <= period_d;
    end
  end

  assign intr_quota_o = intr_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign sweep_done_o = done_q;

endmodule

// File: tb/tb_pmu_quota_sched.sv
// Self-checking bench for pmu_quota_sched: directed scenarios plus a random
// phase, every cycle compared against a slot-level behavioural model.
// Ports: none (top-level bench).
module tb_pmu_quota_sched;

  localparam int RW    = 32;
  localparam int NCNT  = 9;
  localparam int NCORE = 4;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstn, softrst, en;
  logic [RW-1:0]         cnt [NCNT];
  logic [NCNT-1:0]       msk [NCORE];
  logic [RW-1:0]         lim [NCORE];
  logic [RW-1:0]         period;
  logic [NCORE-1:0]      clr;

  logic [NCNT*RW-1:0]    counter_value;
  logic [NCORE*NCNT-1:0] quota_mask;
  logic [NCORE*RW-1:0]   quota_limit;
  logic [NCORE-1:0]      intr_quota_o;
  logic                  busy_o, sweep_done_o;

  always_comb begin
    for (int i = 0; i < NCNT; i++) counter_value[i*RW +: RW] = cnt[i];
    for (int n = 0; n < NCORE; n++) begin
      quota_mask[n*NCNT +: NCNT] = msk[n];
      quota_limit[n*RW +: RW]    = lim[n];
    end
  end

  pmu_quota_sched #(.REG_WIDTH(RW), .N_COUNTERS(NCNT), .N_CORES(NCORE)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .softrst_i       (softrst),
    .en_i            (en),
    .counter_value_i (counter_value),
    .quota_mask_i    (quota_mask),
    .quota_limit_i   (quota_limit),
    .period_i        (period),
    .intr_clr_i      (clr),
    .intr_quota_o    (intr_quota_o),
    .busy_o          (busy_o),
    .sweep_done_o    (sweep_done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: a sweep is a run of slots per core; slots 0..NCNT-1 add counters,
  // slot NCNT is the compare. Sums use 64-bit arithmetic clamped to 32 bits.
  bit               m_active;
  int               m_core, m_pos;
  longint unsigned  m_acc;
  logic [NCNT-1:0]  m_snap;
  logic [NCORE-1:0] m_intr;
  logic             m_done;
  longint unsigned  m_win, m_per;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input longint unsigned per);
    m_active = 1'b0; m_core = 0; m_pos = 0; m_acc = 0; m_snap = '0;
    m_intr = '0; m_win = 0; m_per = per;
  endtask

  task automatic model_step();
    longint unsigned  s;
    logic [NCORE-1:0] set_v;
    logic             expire;
    set_v  = '0;
    expire = 1'b0;
    m_done = 1'b0;
    if (!rstn) begin
      model_clear(0);
    end else if (softrst) begin
      model_clear(longint'(period));
    end else begin
      if (longint'(period) != m_per || period == 0) m_win = 0;
      else if (m_win == longint'(period) - 1) begin m_win = 0; expire = 1'b1; end
      else m_win = m_win + 1;
      m_per = longint'(period);
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1; m_core = 0; m_pos = 0; m_acc = 0; m_snap = msk[0];
        end
      end else if (m_pos < NCNT) begin
        if (msk[m_core] != m_snap) begin
          m_pos = 0; m_acc = 0; m_snap = msk[m_core];
        end else begin
          if (m_snap[m_pos]) begin
            s = m_acc + longint'(cnt[m_pos]);
            m_acc = (s > MAXV) ? MAXV : s;
          end
          m_pos++;
        end
      end else begin
        if (m_acc > longint'(lim[m_core])) set_v[m_core] = 1'b1;
        m_acc = 0; m_pos = 0;
        if (m_core == NCORE - 1) begin
          m_core = 0; m_done = 1'b1; m_active = en;
        end else begin
          m_core++;
        end
        m_snap = msk[m_core];
      end
      m_intr = set_v | (m_intr & ~clr & {NCORE{~expire}});
    end
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("intr",  32'(intr_quota_o), 32'(m_intr));
    chk("busy",  32'(busy_o),       32'(m_active));
    chk("done",  32'(sweep_done_o), 32'(m_done));
  endtask

  task automatic defaults();
    softrst = 1'b0; en = 1'b0; clr = '0; period = '0;
    for (int i = 0; i < NCNT; i++) cnt[i] = 32'd10;
    for (int n = 0; n < NCORE; n++) begin msk[n] = '0; lim[n] = '1; end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    defaults();
    model_clear(0);

    // Reset values
    do_reset();
    chk("rst_intr", 32'(intr_quota_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(sweep_done_o), 32'd0);

    // Nine counters of 10 against limit 89 sets at cycle 11; limit 90 does not
    msk[0] = 9'h1FF; lim[0] = 32'd89; en = 1'b1;
    repeat (10) step();
    chk("s043_pre", 32'(intr_quota_o[0]), 32'd0);
    step();
    chk("s043_set", 32'(intr_quota_o[0]), 32'd1);
    lim[0] = 32'd90; clr = 4'b0001;
    step();
    clr = '0;
    chk("s043_clr", 32'(intr_quota_o[0]), 32'd0);
    repeat (28) step();
    chk("s043_done_early", 32'(sweep_done_o), 32'd0);
    step();
    chk("s043_done40", 32'(sweep_done_o), 32'd1);
    repeat (10) step();
    chk("s043_eqlimit", 32'(intr_quota_o[0]), 32'd0);
    en = 1'b0;
    repeat (40) step();
    chk("s043_idle", 32'(busy_o), 32'd0);

    // Saturation: 0xFFFFFFF0 + 0x20 clamps to all-ones, exceeding 0xFFFFFFFE
    defaults();
    do_reset();
    cnt[0] = 32'hFFFF_FFF0; cnt[1] = 32'h20; msk[1] = 9'h003; lim[1] = 32'hFFFF_FFFE;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (19) step();
    chk("s044_pre", 32'(intr_quota_o[1]), 32'd0);
    step();
    chk("s044_sat", 32'(intr_quota_o[1]), 32'd1);
    clr = 4'b0010;
    step();
    clr = '0;
    repeat (19) step();
    lim[1] = '1; en = 1'b1;
    step();
    en = 1'b0;
    repeat (20) step();
    chk("s044_eqmax", 32'(intr_quota_o[1]), 32'd0);

    // Mask change at core 2's 5th accumulate cycle delays the sweep by 5
    defaults();
    do_reset();
    en = 1'b1;
    msk[2] = 9'h0F0;
    step();
    step();
    en = 1'b0;
    repeat (23) step();
    msk[2] = 9'h00F;
    repeat (16) step();
    chk("s045_not41", 32'(sweep_done_o), 32'd0);
    chk("s045_busy", 32'(busy_o), 32'd1);
    repeat (5) step();
    chk("s045_done46", 32'(sweep_done_o), 32'd1);
    step();
    chk("s045_idle", 32'(busy_o), 32'd0);

    // Window of 100 clears a set from cycle 31; clear coincident with set loses
    defaults();
    do_reset();
    period = 32'd100; en = 1'b1; msk[2] = 9'h1FF; lim[2] = 32'd0;
    step();
    en = 1'b0;
    repeat (29) step();
    chk("s046_pre", 32'(intr_quota_o[2]), 32'd0);
    step();
    chk("s046_set", 32'(intr_quota_o[2]), 32'd1);
    repeat (69) step();
    chk("s046_hold", 32'(intr_quota_o[2]), 32'd1);
    step();
    chk("s046_expire", 32'(intr_quota_o[2]), 32'd0);
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (29) step();
    clr = 4'b0100;
    step();
    clr = '0;
    chk("s046_setwins", 32'(intr_quota_o[2]), 32'd1);

    // One-cycle reset mid-sweep (core 1, k=4), then a clean sweep
    defaults();
    do_reset();
    msk[0] = 9'h1FF; msk[1] = 9'h1FF; lim[0] = 32'd0; lim[1] = 32'd0; en = 1'b1;
    repeat (15) step();
    chk("s047_pre_intr", 32'(intr_quota_o[0]), 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("s047_intr", 32'(intr_quota_o), 32'd0);
    chk("s047_busy", 32'(busy_o), 32'd0);
    chk("s047_done", 32'(sweep_done_o), 32'd0);
    repeat (40) step();
    chk("s047_done_early", 32'(sweep_done_o), 32'd0);
    step();
    chk("s047_done40", 32'(sweep_done_o), 32'd1);

    // Soft reset coincident with en and an interrupt set
    defaults();
    do_reset();
    msk[0] = 9'h1FF; lim[0] = 32'd0; en = 1'b1;
    repeat (10) step();
    softrst = 1'b1;
    step();
    chk("s048_intr", 32'(intr_quota_o), 32'd0);
    chk("s048_busy", 32'(busy_o), 32'd0);
    chk("s048_done", 32'(sweep_done_o), 32'd0);
    softrst = 1'b0; en = 1'b0;
    step();

    // Random phase against the model
    defaults();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 200 == 0) begin
        for (int i = 0; i < NCNT; i++)
          cnt[i] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                               : 32'($urandom_range(0, 1000));
        for (int n = 0; n < NCORE; n++) begin
          msk[n] = 9'($urandom);
          lim[n] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 5000));
        end
        period = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      end
      en      = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      softrst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) msk[$urandom_range(0, NCORE - 1)] = 9'($urandom);
      if ($urandom_range(0, 199) == 0) period = 32'($urandom_range(0, 50));
      step();
    end
    softrst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
